// File: rtl/snake_pkg.sv
// snake_pkg: grid constants, direction/state encodings and coordinate helpers shared by the snake blocks
package snake_pkg;
  localparam int GRID_W = 15;
  localparam int GRID_H = 15;
  localparam int MAX_LEN = 225;
  localparam int INIT_LEN = 3;
  localparam int START_X = 7;
  localparam int START_Y = 7;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, SCAN = 2'd2, COMMIT = 2'd3} state_t;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;
  function automatic coord_t init_coord(int i);
    coord_t c;
    c = '0;
    if (i < INIT_LEN) begin
      c.x = 4'(START_X - i);
      c.y = 4'(START_Y);
    end
    return c;
  endfunction
  function automatic logic [8:0] step_coord(coord_t c, dir_t d);
    logic [3:0] x;
    logic [3:0] y;
    logic wall;
    x = d == LEFT ? (c.x == 4'd0 ? 4'(GRID_W - 1) : c.x - 4'd1) :
        d == RIGHT ? (c.x == 4'(GRID_W - 1) ? 4'd0 : c.x + 4'd1) : c.x;
    y = d == UP ? (c.y == 4'd0 ? 4'(GRID_H - 1) : c.y - 4'd1) :
        d == DOWN ? (c.y == 4'(GRID_H - 1) ? 4'd0 : c.y + 4'd1) : c.y;
    wall = (d == LEFT && c.x == 4'd0) || (d == RIGHT && c.x == 4'(GRID_W - 1)) ||
           (d == UP && c.y == 4'd0) || (d == DOWN && c.y == 4'(GRID_H - 1));
    return {x, y, wall};
  endfunction
endpackage

// File: rtl/snake_body_engine_if.sv
// snake_body_engine_if: control, button, food and renderer signals of the snake body engine
interface snake_body_engine_if;
  logic Init;
  logic Run;
  logic Move_tick;
  logic Btn_U;
  logic Btn_D;
  logic Btn_L;
  logic Btn_R;
  logic [3:0] Food_X;
  logic [3:0] Food_Y;
  logic [7:0] Rd_idx;
  logic [3:0] Rd_X;
  logic [3:0] Rd_Y;
  logic Rd_valid;
  logic [3:0] Head_X;
  logic [3:0] Head_Y;
  logic [7:0] Length;
  logic Collision;
  logic Food_eaten;
  logic Busy;
  modport master (
    output Init, Run, Move_tick, Btn_U, Btn_D, Btn_L, Btn_R, Food_X, Food_Y, Rd_idx,
    input Rd_X, Rd_Y, Rd_valid, Head_X, Head_Y, Length, Collision, Food_eaten, Busy
  );
  modport slave (
    input Init, Run, Move_tick, Btn_U, Btn_D, Btn_L, Btn_R, Food_X, Food_Y, Rd_idx,
    output Rd_X, Rd_Y, Rd_valid, Head_X, Head_Y, Length, Collision, Food_eaten, Busy
  );
endinterface

// File: rtl/snake_dir_latch.sv
// snake_dir_latch: direction buttons with U>D>L>R priority, reversal rejection, dir updated on commit
module snake_dir_latch
  import snake_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Init,
  input  logic btn_u,
  input  logic btn_d,
  input  logic btn_l,
  input  logic btn_r,
  input  logic commit,
  output dir_t pend
);
  dir_t dir_q, dir_d, pend_q, pend_d, sel;
  logic take;
  always_comb begin
    sel = btn_u ? UP : btn_d ? DOWN : btn_l ? LEFT : RIGHT;
    take = (btn_u | btn_d | btn_l | btn_r) && (sel != dir_t'(dir_q ^ 2'd1));
    pend_d = Init ? RIGHT : take ? sel : pend_q;
    dir_d = Init ? RIGHT : commit ? pend_q : dir_q;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dir_q <= RIGHT;
      pend_q <= RIGHT;
    end else begin
      dir_q <= dir_d;
      pend_q <= pend_d;
    end
  end
  assign pend = pend_q;
endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake segment store and step engine (define WRAP_WALLS_EN for wrapping walls)
module snake_body_engine
  import snake_pkg::*;
(
  input logic Clk,
  input logic Reset,
  snake_body_engine_if.slave bus
);
  coord_t seg_q [MAX_LEN];
  coord_t seg_d [MAX_LEN];
  coord_t nxt_q, nxt_d, step_c, rd_c;
  state_t state_q, state_d;
  logic [7:0] length_q, length_d, idx_q, idx_d, limit_q, limit_d, food_c;
  logic grow_q, grow_d, collision_q, collision_d, food_eaten_q, food_eaten_d;
  logic [8:0] step_w;
  logic wall_c, grow_c, commit;
  dir_t pend;
  snake_dir_latch u_dir (
    .Clk(Clk),
    .Reset(Reset),
    .Init(bus.Init),
    .btn_u(bus.Btn_U),
    .btn_d(bus.Btn_D),
    .btn_l(bus.Btn_L),
    .btn_r(bus.Btn_R),
    .commit(commit),
    .pend(pend)
  );
  assign step_w = step_coord(seg_q[0], pend);
  assign step_c = step_w[8:1];
`ifdef WRAP_WALLS_EN
  assign wall_c = 1'b0;
`else
  assign wall_c = step_w[0];
`endif
  assign food_c = {bus.Food_X, bus.Food_Y};
  assign grow_c = step_c == food_c;
  always_comb begin
    seg_d = seg_q;
    state_d = state_q;
    nxt_d = nxt_q;
    grow_d = grow_q;
    idx_d = idx_q;
    limit_d = limit_q;
    length_d = length_q;
    collision_d = collision_q;
    food_eaten_d = 1'b0;
    commit = 1'b0;
    if (bus.Init) begin
      for (int i = 0; i < MAX_LEN; i++) seg_d[i] = init_coord(i);
      state_d = IDLE;
      length_d = 8'(INIT_LEN);
      collision_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = bus.Move_tick && bus.Run && !collision_q ? CALC : IDLE;
        CALC: begin
          nxt_d = step_c;
          grow_d = grow_c;
          idx_d = 8'd0;
          limit_d = length_q - (grow_c ? 8'd1 : 8'd2);
          collision_d = wall_c;
          state_d = wall_c ? IDLE : SCAN;
        end
        SCAN: begin
          collision_d = seg_q[idx_q] == nxt_q;
          state_d = seg_q[idx_q] == nxt_q ? IDLE : idx_q == limit_q ? COMMIT : SCAN;
          idx_d = idx_q + 8'd1;
        end
        default: begin
          for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i - 1];
          seg_d[0] = nxt_q;
          commit = 1'b1;
          length_d = grow_q && length_q != 8'(MAX_LEN) ? length_q + 8'd1 : length_q;
          food_eaten_d = grow_q;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= init_coord(i);
      state_q <= IDLE;
      nxt_q <= '0;
      grow_q <= 1'b0;
      idx_q <= '0;
      limit_q <= '0;
      length_q <= 8'(INIT_LEN);
      collision_q <= 1'b0;
      food_eaten_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      state_q <= state_d;
      nxt_q <= nxt_d;
      grow_q <= grow_d;
      idx_q <= idx_d;
      limit_q <= limit_d;
      length_q <= length_d;
      collision_q <= collision_d;
      food_eaten_q <= food_eaten_d;
    end
  end
  assign rd_c = bus.Rd_idx < 8'(MAX_LEN) ? seg_q[bus.Rd_idx] : '0;
  assign bus.Rd_X = rd_c.x;
  assign bus.Rd_Y = rd_c.y;
  assign bus.Rd_valid = bus.Rd_idx < length_q;
  assign bus.Head_X = seg_q[0].x;
  assign bus.Head_Y = seg_q[0].y;
  assign bus.Length = length_q;
  assign bus.Collision = collision_q;
  assign bus.Food_eaten = food_eaten_q;
  assign bus.Busy = state_q != IDLE;
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: scoreboard bench for the snake body engine
module tb_snake_body_engine;
  typedef struct {
    logic [3:0] hx;
    logic [3:0] hy;
    logic [7:0] len;
    logic col;
    logic fe;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  int mx[225];
  int my[225];
  int mlen, mdir, mpend;
  bit mcol;
  snake_body_engine_if bus();
  snake_body_engine dut (.Clk(clk), .Reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 225; i++) begin
      mx[i] = i < 3 ? 7 - i : 0;
      my[i] = i < 3 ? 7 : 0;
    end
    mlen = 3;
    mdir = 3;
    mpend = 3;
    mcol = 0;
  endtask

  task automatic model_btn(input bit u, input bit d, input bit l, input bit r);
    int sel;
    sel = u ? 0 : d ? 1 : l ? 2 : 3;
    if ((u | d | l | r) && sel != (mdir ^ 1)) mpend = sel;
  endtask

  task automatic model_tick(input int fx, input int fy);
    exp_t e;
    int nx, ny, lim;
    bit grow, hit, out, done;
    grow = 0;
    done = 0;
    if (!mcol) begin
      nx = mx[0] + (mpend == 3 ? 1 : 0) - (mpend == 2 ? 1 : 0);
      ny = my[0] + (mpend == 1 ? 1 : 0) - (mpend == 0 ? 1 : 0);
      out = nx < 0 || nx > 14 || ny < 0 || ny > 14;
`ifdef WRAP_WALLS_EN
      nx = (nx + 15) % 15;
      ny = (ny + 15) % 15;
      out = 0;
`endif
      if (out) mcol = 1;
      else begin
        grow = nx == fx && ny == fy;
        lim = grow ? mlen - 1 : mlen - 2;
        hit = 0;
        for (int i = 0; i <= lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1;
        if (hit) mcol = 1;
        else begin
          for (int i = 224; i > 0; i--) begin
            mx[i] = mx[i - 1];
            my[i] = my[i - 1];
          end
          mx[0] = nx;
          my[0] = ny;
          mdir = mpend;
          if (grow && mlen < 225) mlen++;
          done = 1;
        end
      end
    end
    e.hx = 4'(mx[0]);
    e.hy = 4'(my[0]);
    e.len = 8'(mlen);
    e.col = mcol;
    e.fe = done && grow;
    exp_q.push_back(e);
  endtask

  task automatic finish_step(input string nm);
    exp_t e;
    int n, fe;
    logic fe_after;
    n = 0;
    fe = 0;
    while (bus.Busy === 1'b1 && n < 400) begin
      fe += int'(bus.Food_eaten);
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_timeout busy still %b after %0d cycles, required 0", nm, bus.Busy, n);
    end
    fe += int'(bus.Food_eaten);
    @(negedge clk);
    fe_after = bus.Food_eaten;
    e = exp_q.pop_front();
    checks += 6;
    if (bus.Head_X !== e.hx) begin errors++; $display("FAIL %s_head_x got %0d required %0d", nm, bus.Head_X, e.hx); end
    if (bus.Head_Y !== e.hy) begin errors++; $display("FAIL %s_head_y got %0d required %0d", nm, bus.Head_Y, e.hy); end
    if (bus.Length !== e.len) begin errors++; $display("FAIL %s_length got %0d required %0d", nm, bus.Length, e.len); end
    if (bus.Collision !== e.col) begin errors++; $display("FAIL %s_collision got %b required %b", nm, bus.Collision, e.col); end
    if (fe !== int'(e.fe)) begin errors++; $display("FAIL %s_food_pulses got %0d required %0d", nm, fe, e.fe); end
    if (fe_after !== 1'b0) begin errors++; $display("FAIL %s_food_after got %b required 0", nm, fe_after); end
  endtask

  task automatic do_tick(input int fx, input int fy, input string nm);
    bus.Food_X = 4'(fx);
    bus.Food_Y = 4'(fy);
    model_tick(fx, fy);
    bus.Move_tick = 1'b1;
    @(negedge clk);
    bus.Move_tick = 1'b0;
    finish_step(nm);
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    {bus.Btn_U, bus.Btn_D, bus.Btn_L, bus.Btn_R} = {u, d, l, r};
    model_btn(u, d, l, r);
    @(negedge clk);
    {bus.Btn_U, bus.Btn_D, bus.Btn_L, bus.Btn_R} = 4'b0;
  endtask

  task automatic do_init();
    bus.Init = 1'b1;
    @(negedge clk);
    bus.Init = 1'b0;
    model_reset();
  endtask

  task automatic check_segs(input string nm);
    for (int i = 0; i <= mlen && i < 225; i++) begin
      @(negedge clk);
      bus.Rd_idx = 8'(i);
      #1;
      checks += 3;
      if (bus.Rd_X !== 4'(mx[i])) begin errors++; $display("FAIL %s_seg%0d_x got %0d required %0d", nm, i, bus.Rd_X, mx[i]); end
      if (bus.Rd_Y !== 4'(my[i])) begin errors++; $display("FAIL %s_seg%0d_y got %0d required %0d", nm, i, bus.Rd_Y, my[i]); end
      if (bus.Rd_valid !== (i < mlen)) begin errors++; $display("FAIL %s_seg%0d_valid got %b required %b", nm, i, bus.Rd_valid, i < mlen); end
    end
    @(negedge clk);
  endtask

  task automatic check_const(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s got %0d required %0d", nm, got, want); end
  endtask

  task automatic test_reset();
    model_reset();
    check_const("reset_length", int'(bus.Length), 3);
    check_const("reset_head_x", int'(bus.Head_X), 7);
    check_const("reset_head_y", int'(bus.Head_Y), 7);
    check_const("reset_collision", int'(bus.Collision), 0);
    check_const("reset_busy", int'(bus.Busy), 0);
    check_const("reset_food_eaten", int'(bus.Food_eaten), 0);
    bus.Rd_idx = 8'd2;
    #1;
    check_const("reset_seg2_x", int'(bus.Rd_X), 5);
    check_const("reset_seg2_y", int'(bus.Rd_Y), 7);
    check_const("reset_seg2_valid", int'(bus.Rd_valid), 1);
    bus.Rd_idx = 8'd230;
    #1;
    check_const("rd_oob_x", int'(bus.Rd_X), 0);
    check_const("rd_oob_y", int'(bus.Rd_Y), 0);
    check_const("rd_oob_valid", int'(bus.Rd_valid), 0);
    check_segs("reset");
  endtask

  task automatic test_move();
    do_init();
    do_tick(0, 0, "move");
    check_const("move_head_x", int'(bus.Head_X), 8);
    check_const("move_head_y", int'(bus.Head_Y), 7);
    check_segs("move");
  endtask

  task automatic test_direction();
    do_init();
    press(0, 0, 1, 0);
    do_tick(0, 0, "reverse");
    check_const("reverse_head_x", int'(bus.Head_X), 8);
    do_init();
    press(1, 0, 0, 1);
    do_tick(0, 0, "priority");
    check_const("priority_head_x", int'(bus.Head_X), 7);
    check_const("priority_head_y", int'(bus.Head_Y), 6);
  endtask

  task automatic test_food();
    do_init();
    do_tick(8, 7, "food");
    check_const("food_length", int'(bus.Length), 4);
    check_segs("food");
  endtask

  task automatic test_wall();
    do_init();
    for (int i = 0; i < 7; i++) do_tick(0, 0, "wall_run");
    check_const("wall_pre_head_x", int'(bus.Head_X), 14);
    do_tick(0, 0, "wall_hit");
`ifdef WRAP_WALLS_EN
    check_const("wrap_head_x", int'(bus.Head_X), 0);
    check_const("wrap_collision", int'(bus.Collision), 0);
`else
    check_const("wall_head_x", int'(bus.Head_X), 14);
    check_const("wall_collision", int'(bus.Collision), 1);
`endif
    do_tick(0, 0, "wall_after");
    do_init();
    @(negedge clk);
    check_const("wall_init_collision", int'(bus.Collision), 0);
    check_const("wall_init_length", int'(bus.Length), 3);
  endtask

  task automatic build_loop();
    do_init();
    press(0, 1, 0, 0);
    do_tick(7, 8, "loop_grow");
    press(0, 0, 0, 1);
    do_tick(0, 0, "loop_r");
    press(1, 0, 0, 0);
    do_tick(0, 0, "loop_u");
    press(0, 0, 1, 0);
    do_tick(0, 0, "loop_l");
    press(0, 1, 0, 0);
  endtask

  task automatic test_tail();
    build_loop();
    do_tick(0, 0, "tail_free");
    check_const("tail_free_collision", int'(bus.Collision), 0);
    check_const("tail_free_head_y", int'(bus.Head_Y), 8);
    build_loop();
    do_tick(7, 8, "tail_grow");
    check_const("tail_grow_collision", int'(bus.Collision), 1);
    check_const("tail_grow_head_y", int'(bus.Head_Y), 7);
  endtask

  task automatic test_back_to_back();
    do_init();
    bus.Food_X = 4'd0;
    bus.Food_Y = 4'd0;
    model_tick(0, 0);
    bus.Move_tick = 1'b1;
    @(negedge clk);
    bus.Move_tick = 1'b0;
    @(negedge clk);
    check_const("b2b_busy", int'(bus.Busy), 1);
    bus.Move_tick = 1'b1;
    @(negedge clk);
    bus.Move_tick = 1'b0;
    finish_step("b2b");
    repeat (4) @(negedge clk);
    check_const("b2b_idle", int'(bus.Busy), 0);
    check_const("b2b_one_step", int'(bus.Head_X), 8);
    bus.Run = 1'b0;
    bus.Move_tick = 1'b1;
    @(negedge clk);
    bus.Move_tick = 1'b0;
    check_const("norun_busy", int'(bus.Busy), 0);
    bus.Run = 1'b1;
  endtask

  task automatic test_reset_mid_scan();
    do_init();
    do_tick(0, 0, "pre_reset");
    bus.Move_tick = 1'b1;
    @(negedge clk);
    bus.Move_tick = 1'b0;
    @(negedge clk);
    check_const("mid_scan_busy", int'(bus.Busy), 1);
    #2 reset = 1'b1;
    #1;
    check_const("mid_reset_head_x", int'(bus.Head_X), 7);
    check_const("mid_reset_head_y", int'(bus.Head_Y), 7);
    check_const("mid_reset_busy", int'(bus.Busy), 0);
    check_const("mid_reset_length", int'(bus.Length), 3);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_tick(0, 0, "post_reset");
  endtask

  initial begin
    {bus.Init, bus.Run, bus.Move_tick, bus.Btn_U, bus.Btn_D, bus.Btn_L, bus.Btn_R} = 7'b0;
    bus.Food_X = 4'd0;
    bus.Food_Y = 4'd0;
    bus.Rd_idx = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.Run = 1'b1;
    test_reset();
    test_move();
    test_direction();
    test_food();
    test_wall();
    test_tail();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Upstream feeder of the game control state machine: owns snake segment coordinates on the 15x15 grid.
- Applies direction, advances on each move tick, grows on food, and produces the Collision and Length signals the control SM consumes.
- Also provides a segment read port for the VGA renderer.
- Driven by the SM's q_I (Init) and q_Run (Run) outputs.

Parameters:
- GRID_W, 15, grid columns; x range 0..GRID_W-1.
- GRID_H, 15, grid rows; y range 0..GRID_H-1.
- MAX_LEN, 225, segment storage depth; Length saturates here.
- INIT_LEN, 3, length after reset/Init.
- START_X, 7, initial head x.
- START_Y, 7, initial head y.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Init  in  1  synchronous re-initialise (SM q_I)
- Run  in  1  moves permitted (SM q_Run)
- Move_tick  in  1  one-cycle pulse requesting one step
- Btn_U, Btn_D, Btn_L, Btn_R  in  1 each  debounced single-cycle direction pulses
- Food_X, Food_Y  in  4 each  current food cell
- Rd_idx  in  8  segment index for renderer
- Rd_X, Rd_Y  out  4 each  coordinates of segment Rd_idx
- Rd_valid  out  1  Rd_idx < Length
- Head_X, Head_Y  out  4 each  segment 0 coordinates
- Length  out  8  current segment count
- Collision  out  1  sticky collision flag
- Food_eaten  out  1  one-cycle pulse on growth commit
- Busy  out  1  step in progress

Behaviour:
- Reset (async) and Init (sync, highest synchronous priority) set the same state:
  - Segments: seg[0]=(START_X,START_Y), seg[i]=(START_X-i,START_Y) for i<INIT_LEN; other entries (0,0).
  - Length=INIT_LEN; dir=pend=RIGHT; Collision=0, Food_eaten=0, Busy=0; FSM to IDLE.
- Init mid-step aborts the step; no segment update.
- Direction:
  - A button pulse loads pend unless it is the opposite of dir, which is ignored.
  - Simultaneous pulses: priority U>D>L>R, before the reversal check.
  - dir<=pend at commit only.
  - Buttons are accepted in every state.
- FSM states:
  - IDLE: Move_tick & Run & !Collision -> CALC. Move_tick otherwise, or while Busy, is dropped.
  - CALC (1 cycle):
    - nxt = seg[0] stepped by pend; grow = (nxt == Food).
    - Out-of-range nxt (x=0 moving left, x=GRID_W-1 moving right, likewise y) sets Collision -> IDLE.
    - Otherwise idx=0 -> SCAN. limit = Length-1 if grow, else Length-2.
  - SCAN (one compare per cycle, idx 0..limit):
    - seg[idx]==nxt sets Collision -> IDLE.
    - idx==limit without a hit -> COMMIT.
    - The tail is excluded when not growing because it vacates this step.
  - COMMIT (1 cycle):
    - seg[i]<=seg[i-1] for i=1..MAX_LEN-1; seg[0]<=nxt; dir<=pend.
    - If grow: Length<=min(Length+1,MAX_LEN) and Food_eaten=1 this cycle only.
    - -> IDLE.
- Busy=1 in CALC/SCAN/COMMIT. Worst-case step is Length+2 cycles, so the tick period must be ≥MAX_LEN+3 clocks.
- On collision no segments move, so the head stays at its pre-step cell.
- Collision stays 1 until Reset/Init; Run low does not clear it.
- Length==MAX_LEN is held; the control SM declares win. A further growth step shifts without incrementing.
- Rd_X/Rd_Y are combinational from seg[Rd_idx]. Rd_idx≥MAX_LEN returns (0,0) with Rd_valid=0.

Optional Feature:
- WRAP_WALLS_EN defined: out-of-range nxt wraps (x=GRID_W-1 right -> 0; x=0 left -> GRID_W-1; same for y). Walls never collide; only self-collision sets Collision.
- Undefined: wall collision as specified above.

Decomposition:
- Shared package snake_pkg:
  - direction encodings UP=2'd0, DOWN=2'd1, LEFT=2'd2, RIGHT=2'd3;
  - FSM state encodings;
  - grid constants (GRID_W, GRID_H, MAX_LEN), also used by the control SM (win length 225) and the food generator.
- One natural sub-module: snake_dir_latch (button priority, reversal rejection, pend/dir registers, commit input).

Test Plan:
- Reset -> Length=3, Head=(7,7), Rd_idx=2 gives (5,7), Collision=0; one tick with Run=1 -> after ≤5 cycles Head=(8,7), seg[2]=(6,7), Length=3.
- Heading RIGHT, pulse Btn_L then tick -> Head=(8,7) (reversal ignored); Btn_U and Btn_R same cycle then tick -> Head=(7,6).
- Food=(8,7), tick -> Length=4, Food_eaten high exactly one cycle, seg[3]=(5,7).
- Head at (14,7) RIGHT, tick -> Collision=1, Head stays (14,7); further ticks ignored; Init -> Collision=0, Length=3. With WRAP_WALLS_EN -> Head=(0,7), Collision=0.
- Length 4 loop at (7,7),(7,8),(8,8),(8,7): tick moving DOWN into tail (7,8) without food -> no collision. Same with Food=(7,8) -> Collision=1.
- Tick while Busy=1 -> dropped, exactly one step taken; Reset asserted mid-SCAN -> immediate reset values.
